rice_encoder: RTL and testbench

Golomb-Rice bitstream encoder: accepts one unsigned sample plus Rice parameter k per handshake, forms the codeword (unary quotient as leading zeros terminated by a one, then k remainder bits), and packs codewords MSB-first into fixed-width output words. It is the transmit-side counterpart of the leading-zero-count based Rice decoder. The decoder recovers the quotient by counting leading zeros in the same bit order, so the two blocks share one stream format. A flush request pads the final partial word with zeros and marks it last.

---
 rtl/rice_enc_if.sv | 28 ++
 rtl/rice_encoder.sv | 142 ++++++++++++++
 tb/tb_rice_encoder.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/rice_enc_if.sv
// Handshake bundle for the Golomb-Rice encoder: sample input, word output, flush control.
interface rice_enc_if #(
    parameter int unsigned W_DATA = 16,
    parameter int unsigned W_K    = 4,
    parameter int unsigned W_OUT  = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [W_DATA-1:0] in_data;
    logic [W_K-1:0]    in_k;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [W_OUT-1:0]  out_data;
    logic              out_last;
    logic              flush_done;
    logic              err;

    modport master (
        output in_valid, in_data, in_k, flush, out_ready,
        input  in_ready, out_valid, out_data, out_last, flush_done, err
    );

    modport slave (
        input  in_valid, in_data, in_k, flush, out_ready,
        output in_ready, out_valid, out_data, out_last, flush_done, err
    );
endinterface

// File: rtl/rice_encoder.sv
// Golomb-Rice encoder packing codewords MSB-first into W_OUT-bit words, with flush/last.
// Optional escape coding for large quotients is enabled by defining RICE_ENC_ESCAPE_EN.
module rice_encoder #(
    parameter int unsigned W_DATA = 16,
    parameter int unsigned W_K    = 4,
    parameter int unsigned W_OUT  = 32,
    parameter int unsigned Q_ESC  = 15
) (
    input  logic     clk,
    input  logic     rst_n,
    rice_enc_if.slave bus
);
    localparam int unsigned W_ACC  = 2 * W_OUT;
    localparam int unsigned W_FILL = $clog2(W_ACC + 1);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [W_ACC-1:0]  acc_q, acc_d;
    logic [W_FILL-1:0] fill_q, fill_d;
    logic              err_q, err_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [W_OUT-1:0]  out_data_q, out_data_d;
    logic              in_ready_q, in_ready_d;
    logic              flush_done_q, flush_done_d;

    logic [W_K-1:0]    k_eff;
    logic [W_DATA-1:0] quo;
    logic [W_DATA-1:0] rem;
    logic              is_esc;
    logic [W_OUT-1:0]  cw_val;
    logic [W_FILL-1:0] cw_len;
    logic [W_ACC-1:0]  cw_acc;
    logic              accept;
    logic              pop;

    // Codeword formation: right-aligned value plus length, then placed just below the fill point.
    always_comb begin
        k_eff = bus.in_k;
        if (32'(bus.in_k) >= W_DATA) k_eff = W_K'(W_DATA - 1);
        quo    = bus.in_data >> k_eff;
        rem    = bus.in_data & ((W_DATA'(1) << k_eff) - W_DATA'(1));
        is_esc = (quo >= W_DATA'(Q_ESC));
        cw_val = (W_OUT'(1) << k_eff) | W_OUT'(rem);
        cw_len = W_FILL'(quo) + W_FILL'(k_eff) + W_FILL'(1);
        if (is_esc) begin
`ifdef RICE_ENC_ESCAPE_EN
            cw_val = (W_OUT'(1) << W_DATA) | W_OUT'(bus.in_data);
            cw_len = W_FILL'(Q_ESC + 1 + W_DATA);
`else
            cw_val = '0;
            cw_len = '0;
`endif
        end
        cw_acc = W_ACC'(cw_val) << (W_FILL'(W_ACC) - fill_q - cw_len);
    end

    assign accept = bus.in_valid && in_ready_q;
    assign pop    = out_valid_q && bus.out_ready;

    // Next-state: accumulator, fill, FSM, and registered outputs decoded from the next state.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        fill_d  = fill_q;
        err_d   = err_q;

        case (state_q)
            S_RUN: begin
                if (pop) begin
                    acc_d  = acc_q << W_OUT;
                    fill_d = fill_q - W_FILL'(W_OUT);
                end else if (accept) begin
                    acc_d  = acc_q | cw_acc;
                    fill_d = fill_q + cw_len;
`ifdef RICE_ENC_ESCAPE_EN
                    err_d  = 1'b0;
`else
                    if (is_esc) err_d = 1'b1;
`endif
                end
                if (bus.flush) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                if (fill_q == '0) begin
                    state_d = S_DONE;
                end else if (pop) begin
                    acc_d = acc_q << W_OUT;
                    if (fill_q >= W_FILL'(W_OUT)) begin
                        fill_d = fill_q - W_FILL'(W_OUT);
                    end else begin
                        fill_d  = '0;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_RUN;
            default: state_d = S_RUN;
        endcase

        out_valid_d  = ((state_d == S_RUN) && (fill_d >= W_FILL'(W_OUT))) ||
                       ((state_d == S_FLUSH) && (fill_d != '0));
        out_last_d   = (state_d == S_FLUSH) && (fill_d != '0) && (fill_d < W_FILL'(W_OUT));
        out_data_d   = acc_d[W_ACC-1 -: W_OUT];
        in_ready_d   = (state_d == S_RUN) && (fill_d < W_FILL'(W_OUT));
        flush_done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_RUN;
            acc_q        <= '0;
            fill_q       <= '0;
            err_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            in_ready_q   <= 1'b1;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            fill_q       <= fill_d;
            err_q        <= err_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
            in_ready_q   <= in_ready_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_last   = out_last_q;
    assign bus.out_data   = out_data_q;
    assign bus.flush_done = flush_done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_rice_encoder.sv
// Directed self-checking bench for rice_encoder (default W_DATA=16, W_K=4, W_OUT=32, Q_ESC=15).
module tb_rice_encoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rice_enc_if #(.W_DATA(16), .W_K(4), .W_OUT(32)) bus ();

    rice_encoder #(.W_DATA(16), .W_K(4), .W_OUT(32), .Q_ESC(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_pass = 0;
    int n_total = 0;
    logic [31:0] words[$];
    logic        lasts[$];
    int done_cnt = 0;
    int stall_cnt = 0;
    bit count_stall = 1'b0;

    // Word/pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            words.push_back(bus.out_data);
            lasts.push_back(bus.out_last);
        end
        if (bus.flush_done) done_cnt++;
        if (count_stall && !bus.in_ready) stall_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic [3:0] k);
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_k     = k;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (bus.in_ready) ok = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            n_total++;
            $display("FAIL send_timeout: data %h never accepted", d);
        end
    endtask

    task automatic do_flush();
        int d0 = done_cnt;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        for (int i = 0; i < 20 && done_cnt == d0; i++) tick();
        tick();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.out_data !== 32'h0) $display("FAIL rst_out_data: got %h want 0", bus.out_data); else n_pass++;
        n_total++; if (bus.out_last !== 1'b0) $display("FAIL rst_out_last: got %b want 0", bus.out_last); else n_pass++;
        n_total++; if (bus.flush_done !== 1'b0) $display("FAIL rst_flush_done: got %b want 0", bus.flush_done); else n_pass++;
        n_total++; if (bus.err !== 1'b0) $display("FAIL rst_err: got %b want 0", bus.err); else n_pass++;
        rst_n = 1'b1;
        tick();
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); else n_pass++;
    endtask

    task automatic test_pack();
        logic [31:0] w;
        int d0;
        words.delete(); lasts.delete();
        stall_cnt = 0;
        count_stall = 1'b1;
        for (int i = 0; i < 7; i++) send(16'd9, 4'd2);
        repeat (3) tick();
        count_stall = 1'b0;
        n_total++; if (words.size() !== 1) $display("FAIL pack_count: got %0d want 1", words.size()); else n_pass++;
        w = (words.size() > 0) ? words[0] : 32'hx;
        n_total++; if (w !== 32'h294A5294) $display("FAIL pack_word: got %h want 294a5294", w); else n_pass++;
        n_total++; if (lasts.size() == 0 || lasts[0] !== 1'b0) $display("FAIL pack_last: got %0d entries want last=0", lasts.size()); else n_pass++;
        n_total++; if (stall_cnt !== 1) $display("FAIL pack_stall: got %0d want 1", stall_cnt); else n_pass++;
        // Leftover 3 bits "101" must come out padded and marked last.
        d0 = done_cnt;
        do_flush();
        w = (words.size() > 1) ? words[1] : 32'hx;
        n_total++; if (w !== 32'hA0000000) $display("FAIL pack_tail: got %h want a0000000", w); else n_pass++;
        n_total++; if (lasts.size() < 2 || lasts[1] !== 1'b1) $display("FAIL pack_tail_last: got %0d entries want last=1", lasts.size()); else n_pass++;
        n_total++; if (done_cnt - d0 !== 1) $display("FAIL pack_done: got %0d want 1", done_cnt - d0); else n_pass++;
    endtask

    task automatic test_escape();
        logic [31:0] w;
        words.delete(); lasts.delete();
        send(16'hFFFF, 4'd0);
        repeat (3) tick();
`ifdef RICE_ENC_ESCAPE_EN
        w = (words.size() > 0) ? words[0] : 32'hx;
        n_total++; if (w !== 32'h0001FFFF) $display("FAIL esc_word: got %h want 0001ffff", w); else n_pass++;
        n_total++; if (lasts.size() == 0 || lasts[0] !== 1'b0) $display("FAIL esc_last: got %0d entries want last=0", lasts.size()); else n_pass++;
        n_total++; if (bus.err !== 1'b0) $display("FAIL esc_err: got %b want 0", bus.err); else n_pass++;
`else
        n_total++; if (words.size() !== 0) $display("FAIL noesc_count: got %0d want 0", words.size()); else n_pass++;
        n_total++; if (bus.err !== 1'b1) $display("FAIL noesc_err: got %b want 1", bus.err); else n_pass++;
`endif
    endtask

    task automatic test_flush_single();
        logic [31:0] w;
        int d0;
        words.delete(); lasts.delete();
        d0 = done_cnt;
        send(16'd0, 4'd0);
        do_flush();
        n_total++; if (words.size() !== 1) $display("FAIL fl1_count: got %0d want 1", words.size()); else n_pass++;
        w = (words.size() > 0) ? words[0] : 32'hx;
        n_total++; if (w !== 32'h80000000) $display("FAIL fl1_word: got %h want 80000000", w); else n_pass++;
        n_total++; if (lasts.size() == 0 || lasts[0] !== 1'b1) $display("FAIL fl1_last: got %0d entries want last=1", lasts.size()); else n_pass++;
        n_total++; if (done_cnt - d0 !== 1) $display("FAIL fl1_done: got %0d want 1", done_cnt - d0); else n_pass++;
    endtask

    task automatic test_flush_empty();
        words.delete(); lasts.delete();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        n_total++; if (bus.flush_done !== 1'b0) $display("FAIL fl0_done_early: got %b want 0", bus.flush_done); else n_pass++;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL fl0_valid: got %b want 0", bus.out_valid); else n_pass++;
        tick();
        n_total++; if (bus.flush_done !== 1'b1) $display("FAIL fl0_done: got %b want 1", bus.flush_done); else n_pass++;
        tick();
        n_total++; if (bus.flush_done !== 1'b0) $display("FAIL fl0_done_pulse: got %b want 0", bus.flush_done); else n_pass++;
        n_total++; if (words.size() !== 0) $display("FAIL fl0_count: got %0d want 0", words.size()); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL fl0_ready: got %b want 1", bus.in_ready); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [31:0] w;
        words.delete(); lasts.delete();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 7; i++) send(16'd9, 4'd2);
        n_total++; if (bus.out_valid !== 1'b1) $display("FAIL bp_valid: got %b want 1", bus.out_valid); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            n_total++; if (bus.out_data !== 32'h294A5294) $display("FAIL bp_hold_data: cycle %0d got %h want 294a5294", i, bus.out_data); else n_pass++;
            n_total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_hold_ready: cycle %0d got %b want 0", i, bus.in_ready); else n_pass++;
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL bp_popped: got %b want 0", bus.out_valid); else n_pass++;
        w = (words.size() == 1) ? words[0] : 32'hx;
        n_total++; if (w !== 32'h294A5294) $display("FAIL bp_word: got %h want 294a5294 (%0d words)", w, words.size()); else n_pass++;
        do_flush();
        w = (words.size() > 1) ? words[1] : 32'hx;
        n_total++; if (w !== 32'hA0000000) $display("FAIL bp_tail: got %h want a0000000", w); else n_pass++;
    endtask

    task automatic test_reset_mid_flush();
        logic [31:0] w;
        int d0;
        words.delete(); lasts.delete();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(16'd9, 4'd2);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        n_total++; if (bus.out_data !== 32'h294A5000) $display("FAIL rmf_data: got %h want 294a5000", bus.out_data); else n_pass++;
        n_total++; if (bus.out_last !== 1'b1) $display("FAIL rmf_last: got %b want 1", bus.out_last); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rmf_rst_valid: got %b want 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.out_data !== 32'h0) $display("FAIL rmf_rst_data: got %h want 0", bus.out_data); else n_pass++;
        n_total++; if (bus.out_last !== 1'b0) $display("FAIL rmf_rst_last: got %b want 0", bus.out_last); else n_pass++;
        n_total++; if (bus.err !== 1'b0) $display("FAIL rmf_rst_err: got %b want 0", bus.err); else n_pass++;
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        d0 = done_cnt;
        repeat (5) tick();
        n_total++; if (words.size() !== 0) $display("FAIL rmf_no_word: got %0d want 0", words.size()); else n_pass++;
        n_total++; if (done_cnt - d0 !== 0) $display("FAIL rmf_no_done: got %0d want 0", done_cnt - d0); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL rmf_ready: got %b want 1", bus.in_ready); else n_pass++;
        send(16'd0, 4'd0);
        do_flush();
        w = (words.size() > 0) ? words[0] : 32'hx;
        n_total++; if (w !== 32'h80000000) $display("FAIL rmf_next: got %h want 80000000", w); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_k      = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_pack();
        test_escape();
        test_flush_single();
        test_flush_empty();
        test_backpressure();
        test_reset_mid_flush();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
